// File: rtl/rc4_core_prga_xor_pkg.sv
// Shared widths and FSM encoding for the RC4 PRGA/XOR stage.
// Imported as rc4_pkg by the interface, the core and the bench.
package rc4_pkg;

  localparam int RC4_BYTES_PER_WORD = 4;
  localparam int RC4_SBOX_AW        = 8;
  localparam int RC4_DW             = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_SI = 3'd1,
    ST_RD_SJ = 3'd2,
    ST_WR_SI = 3'd3,
    ST_WR_SJ = 3'd4,
    ST_RD_K  = 3'd5,
    ST_OUT   = 3'd6
  } rc4_state_e;

endpackage

// File: rtl/rc4_core_prga_xor_if.sv
// S-box RAM port plus decrypted-byte strobe towards the packer.
// master = PRGA core, slave = RAM/packer side.
interface rc4_core_prga_xor_if
  import rc4_pkg::*;
();

  logic [RC4_SBOX_AW-1:0] sbox_addr_o;
  logic                   sbox_wen_o;
  logic [RC4_DW-1:0]      sbox_wdata_o;
  logic [RC4_DW-1:0]      sbox_rdata_i;
  logic                   enable_write_o;
  logic [1:0]             writeLoc_o;
  logic [RC4_DW-1:0]      data_o;

  modport master (
    output sbox_addr_o,
    output sbox_wen_o,
    output sbox_wdata_o,
    input  sbox_rdata_i,
    output enable_write_o,
    output writeLoc_o,
    output data_o
  );

  modport slave (
    input  sbox_addr_o,
    input  sbox_wen_o,
    input  sbox_wdata_o,
    output sbox_rdata_i,
    input  enable_write_o,
    input  writeLoc_o,
    input  data_o
  );

endinterface

// File: rtl/rc4_core_prga_xor.sv
// RC4 PRGA over an external S-box RAM, XOR with one 32-bit word.
// Optional debug port keystream_o under RC4_KEYSTREAM_OUT_EN.
module rc4_core_prga_xor
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        init_i,
  input  logic [31:0] cipher_i,
  output logic        busy_o,
  output logic        done_o,
`ifdef RC4_KEYSTREAM_OUT_EN
  output logic [7:0]  keystream_o,
`endif
  rc4_core_prga_xor_if.master bus
);

  rc4_state_e        r_state;
  logic [RC4_DW-1:0] r_i;
  logic [RC4_DW-1:0] r_j;
  logic [RC4_DW-1:0] r_si;
  logic [RC4_DW-1:0] r_sj;
  logic [1:0]        r_idx;
  logic [31:0]       r_cipher;

  logic [RC4_DW-1:0] w_rd;
  logic [RC4_DW-1:0] w_i_base;
  logic [RC4_DW-1:0] w_byte;

  assign w_rd     = bus.sbox_rdata_i;
  assign w_i_base = init_i ? '0 : r_i;
  assign busy_o   = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_si     <= '0;
      r_sj     <= '0;
      r_idx    <= '0;
      r_cipher <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // init clears first so a combined init+start begins at i=1
          if (init_i) r_j <= '0;
          if (start_i) begin
            r_cipher <= cipher_i;
            r_idx    <= '0;
            r_i      <= w_i_base + 8'd1;
            r_state  <= ST_RD_SI;
          end else if (init_i) begin
            r_i <= '0;
          end
        end
        ST_RD_SI: r_state <= ST_RD_SJ;
        ST_RD_SJ: begin
          r_si    <= w_rd;
          r_j     <= r_j + w_rd;
          r_state <= ST_WR_SI;
        end
        ST_WR_SI: begin
          r_sj    <= w_rd;
          r_state <= ST_WR_SJ;
        end
        ST_WR_SJ: r_state <= ST_RD_K;
        ST_RD_K:  r_state <= ST_OUT;
        ST_OUT: begin
          if (r_idx == 2'd3) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_i     <= r_i + 8'd1;
            r_state <= ST_RD_SI;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = r_cipher[31:24];
    unique case (r_idx)
      2'd0: w_byte = r_cipher[31:24];
      2'd1: w_byte = r_cipher[23:16];
      2'd2: w_byte = r_cipher[15:8];
      2'd3: w_byte = r_cipher[7:0];
    endcase
  end

  always_comb begin
    bus.sbox_addr_o    = '0;
    bus.sbox_wen_o     = 1'b0;
    bus.sbox_wdata_o   = '0;
    bus.enable_write_o = 1'b0;
    bus.writeLoc_o     = '0;
    bus.data_o         = '0;
    done_o             = 1'b0;
    unique case (r_state)
      ST_RD_SI: bus.sbox_addr_o = r_i;
      ST_RD_SJ: bus.sbox_addr_o = r_j + w_rd;
      ST_WR_SI: begin
        bus.sbox_addr_o  = r_i;
        bus.sbox_wen_o   = 1'b1;
        bus.sbox_wdata_o = w_rd;
      end
      ST_WR_SJ: begin
        bus.sbox_addr_o  = r_j;
        bus.sbox_wen_o   = 1'b1;
        bus.sbox_wdata_o = r_si;
      end
      // post-swap S[i]+S[j] equals the held si+sj after the exchange
      ST_RD_K: bus.sbox_addr_o = r_si + r_sj;
      ST_OUT: begin
        bus.enable_write_o = 1'b1;
        bus.writeLoc_o     = r_idx;
        bus.data_o         = w_byte ^ w_rd;
        done_o             = (r_idx == 2'd3);
      end
      default: ;
    endcase
  end

`ifdef RC4_KEYSTREAM_OUT_EN
  assign keystream_o = (r_state == ST_OUT) ? w_rd : '0;
`endif

endmodule

// File: tb/tb_rc4_core_prga_xor.sv
// Bench for rc4_core_prga_xor: behavioural RC4 model, RAM model,
// per-cycle compare of strobes, lanes, busy and done.
module tb_rc4_core_prga_xor;
  import rc4_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic [7:0] k;
    logic [1:0] lane;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        init_i = 1'b0;
  logic [31:0] cipher_i = '0;
  logic        busy_o;
  logic        done_o;
`ifdef RC4_KEYSTREAM_OUT_EN
  logic [7:0]  keystream_o;
`endif

  rc4_core_prga_xor_if bus();

  rc4_core_prga_xor dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .init_i   (init_i),
    .cipher_i (cipher_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
`ifdef RC4_KEYSTREAM_OUT_EN
    .keystream_o (keystream_o),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_done = 0;
  logic [31:0] packed_w = '0;

  exp_t q[$];
  int   starts[$];

  // S-box RAM: synchronous read, one access per cycle
  logic [7:0] mem [256];
  logic [7:0] ld  [256];
  logic       load_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_en) begin
      for (int k = 0; k < 256; k++) mem[k] <= ld[k];
    end else if (bus.sbox_wen_o) begin
      mem[bus.sbox_addr_o] <= bus.sbox_wdata_o;
    end
    bus.sbox_rdata_i <= mem[bus.sbox_addr_o];
  end

  // golden RC4 state
  logic [7:0] gs [256];
  logic [7:0] mi = '0;
  logic [7:0] mj = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cyc %0d",
               name, act, req, cyc);
    end
  endtask

  task automatic model_byte(output logic [7:0] kb);
    logic [7:0] t;
    mi = mi + 8'd1;
    mj = mj + gs[mi];
    t = gs[mi];
    gs[mi] = gs[mj];
    gs[mj] = t;
    t = gs[mi] + gs[mj];
    kb = gs[t];
  endtask

  task automatic apply_load();
    @(negedge clk);
    for (int k = 0; k < 256; k++) gs[k] = ld[k];
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_identity();
    for (int k = 0; k < 256; k++) ld[k] = k[7:0];
    apply_load();
  endtask

  // queue the 4 expected bytes of a word accepted at the next edge
  task automatic push_word(input int s, input logic [31:0] c,
                           output logic [31:0] ks);
    logic [7:0] kb;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      model_byte(kb);
      e.k = kb;
      e.d = c[8*(3-k) +: 8] ^ kb;
      e.lane = k[1:0];
      e.cyc = s + 6 + 6 * k;
      q.push_back(e);
      ks[8*(3-k) +: 8] = kb;
    end
    starts.push_back(s);
  endtask

  task automatic start_word(input logic [31:0] c, input bit ini,
                            output logic [31:0] ks);
    int s;
    @(negedge clk);
    s = cyc;
    start_i = 1'b1;
    init_i = ini;
    cipher_i = c;
    if (ini) begin
      mi = '0;
      mj = '0;
    end
    push_word(s, c, ks);
    @(negedge clk);
    start_i = 1'b0;
    init_i = 1'b0;
  endtask

  // per-cycle comparison against the model queue
  always @(negedge clk) begin
    logic bexp;
    exp_t e;
    if (rst) begin
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_en", {31'd0, bus.enable_write_o}, 32'd0);
      chk("rst_data", {24'd0, bus.data_o}, 32'd0);
      chk("rst_lane", {30'd0, bus.writeLoc_o}, 32'd0);
      chk("rst_wen", {31'd0, bus.sbox_wen_o}, 32'd0);
      chk("rst_addr", {24'd0, bus.sbox_addr_o}, 32'd0);
    end else begin
      bexp = 1'b0;
      foreach (starts[n])
        if (cyc > starts[n] && cyc <= starts[n] + 24) bexp = 1'b1;
      chk("busy", {31'd0, busy_o}, {31'd0, bexp});
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missing_strobe", cyc, e.cyc);
      end
      if (bus.enable_write_o) begin
        n_strobe++;
        if (done_o) n_done++;
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("data", {24'd0, bus.data_o}, {24'd0, e.d});
          chk("lane", {30'd0, bus.writeLoc_o}, {30'd0, e.lane});
          chk("done", {31'd0, done_o}, {31'd0, e.lane == 2'd3});
`ifdef RC4_KEYSTREAM_OUT_EN
          chk("keystream", {24'd0, keystream_o}, {24'd0, e.k});
`endif
        end
        packed_w[8*(3-bus.writeLoc_o) +: 8] = bus.data_o;
      end else begin
        chk("idle_data", {24'd0, bus.data_o}, 32'd0);
        chk("idle_done", {31'd0, done_o}, 32'd0);
`ifdef RC4_KEYSTREAM_OUT_EN
        chk("idle_ks", {24'd0, keystream_o}, 32'd0);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ks;
    logic [7:0]  key [16];
    logic [7:0]  kj, t;
    int s0, ns, nd, s;

    repeat (3) @(negedge clk);
    load_identity();
    rst = 1'b0;
    @(negedge clk);

    // identity S-box, zero cipher
    start_word(32'h0000_0000, 1'b0, ks);
    chk("model_id_ks", ks, 32'h0205_070D);
    repeat (26) @(negedge clk);
    chk("packer_zero", packed_w, 32'h0205_070D);
    chk("strobes_w0", n_strobe, 4);
    chk("dones_w0", n_done, 1);

    // identity S-box, all-ones cipher
    load_identity();
    start_word(32'hFFFF_FFFF, 1'b1, ks);
    chk("model_ff", ks ^ 32'hFFFF_FFFF, 32'hFDFA_F8F2);
    repeat (26) @(negedge clk);
    chk("packer_ff", packed_w, 32'hFDFA_F8F2);

    // init with start restarts the keystream
    load_identity();
    start_word(32'h0000_0000, 1'b1, ks);
    repeat (26) @(negedge clk);
    chk("packer_reinit", packed_w, 32'h0205_070D);

    // start pulses mid-word are ignored
    ns = n_strobe;
    nd = n_done;
    start_word(32'h1234_5678, 1'b0, ks);
    repeat (4) @(negedge clk);
    start_i = 1'b1;
    cipher_i = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    start_i = 1'b1;
    init_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    init_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignored_strobes", n_strobe - ns, 4);
    chk("ignored_dones", n_done - nd, 1);

    // reset mid-word
    load_identity();
    start_word(32'hA5A5_5A5A, 1'b1, ks);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    starts.delete();
    mi = '0;
    mj = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
    load_identity();
    start_word(32'h0000_0000, 1'b0, ks);
    repeat (26) @(negedge clk);
    chk("packer_after_rst", packed_w, 32'h0205_070D);

    // random KSA, 64 back-to-back words, i wraps 255->0
    for (int k = 0; k < 16; k++) key[k] = 8'($urandom);
    for (int k = 0; k < 256; k++) ld[k] = k[7:0];
    kj = '0;
    for (int k = 0; k < 256; k++) begin
      kj = kj + ld[k] + key[k % 16];
      t = ld[k];
      ld[k] = ld[kj];
      ld[kj] = t;
    end
    apply_load();
    ns = n_strobe;
    @(negedge clk);
    s0 = cyc;
    mi = '0;
    mj = '0;
    for (int w = 0; w < 64; w++) begin
      s = s0 + 25 * w;
      start_i = 1'b1;
      init_i = (w == 0);
      cipher_i = $urandom;
      push_word(s, cipher_i, ks);
      @(negedge clk);
      init_i = 1'b0;
      if (w == 63) start_i = 1'b0;
      else repeat (24) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("b2b_strobes", n_strobe - ns, 256);
    chk("model_i_wrapped", {24'd0, mi}, 32'd0);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_core_prga_xor.md
# rc4_core_prga_xor

Upstream stage of the RC4 decrypted-data word packer. It runs the RC4 pseudo-random generation algorithm (PRGA) against an external, already-initialised 256-byte S-box RAM and XORs each keystream byte with one ciphertext byte. Each decrypted byte is driven to the packer with its byte lane, MSB-first. One 32-bit ciphertext word is processed per `start_i`.

## Interface
- No parameters. Widths are fixed by the shared package.
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  begin one word; sampled only in IDLE
- `init_i`  in  1  clear i, j to 0 (new message); sampled only in IDLE
- `cipher_i`  in  32  ciphertext word; captured on accepted start
- `busy_o`  out  1  high while a word is in progress
- `done_o`  out  1  pulse with the 4th byte's write strobe
- `sbox_addr_o`  out  8  S-box RAM address
- `sbox_wen_o`  out  1  S-box RAM write enable
- `sbox_wdata_o`  out  8  S-box RAM write data
- `sbox_rdata_i`  in  8  S-box RAM read data, valid the cycle after the address
- `enable_write_o`  out  1  decrypted byte valid, to the packer
- `writeLoc_o`  out  2  byte lane: 0 → [31:24], 3 → [7:0]
- `data_o`  out  8  decrypted byte; 0 when `enable_write_o` is low

## Operation
- FSM states: IDLE, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_K, OUT.
- IDLE:
  - `init_i` clears i and j.
  - `start_i` captures `cipher_i`, clears the byte index, sets i←i+1 and moves to RD_SI.
  - If `init_i` and `start_i` are both high, the clear applies first, so the word starts with i=1, j=0.
- RD_SI: addr=i.
- RD_SJ: si←rdata; j←j+rdata (mod 256); addr=j+rdata.
- WR_SI: sj←rdata; write S[i]=rdata.
- WR_SJ: write S[j]=si.
- RD_K: addr=si+sj (mod 256). This read happens after the swap, as RC4 requires.
- OUT:
  - `enable_write_o`=1; `writeLoc_o`=byte index; `data_o`=cipher byte[index] ^ `sbox_rdata_i`. Output is combinational from the RAM read.
  - If index==3: assert `done_o` and go to IDLE.
  - Otherwise: index+1, i←i+1, go to RD_SI.
- All index arithmetic is 8-bit and wraps modulo 256. i wraps 255→0.
- `start_i` and `init_i` are ignored outside IDLE.
- i and j persist across words; only `init_i` or `rst` clears them.

## Timing
- Reset: state IDLE; i, j, index, captured cipher = 0.
- Reset value of every output is 0.
- `rst` mid-word aborts immediately. The S-box may be left partially swapped; software re-runs KSA.
- Start accepted at edge 0: busy high cycles 1–24.
- Byte k OUT occurs in cycle 6+6k, so cycles 6, 12, 18, 24.
- `done_o` is asserted in cycle 24; IDLE in cycle 25.
- Throughput: 25 cycles per word if `start_i` is held high.
- `sbox_wen_o` is high only in WR_SI and WR_SJ. Never more than one RAM access per cycle.

## Configuration
- `RC4_KEYSTREAM_OUT_EN` defined: adds output `keystream_o[7:0]` = `sbox_rdata_i` during OUT, else 0, for debug comparison.
- Macro undefined: port absent; behaviour otherwise identical.

## Structure
- Package `rc4_pkg`:
  - FSM state enum typedef.
  - `RC4_BYTES_PER_WORD`=4, `RC4_SBOX_AW`=8, `RC4_DW`=8.
- Single module, no sub-module. The byte-select mux is inline.

## Test plan
- Identity S-box (S[k]=k), reset, then start with cipher 0x00000000. Required response:
  - bytes 0x02, 0x05, 0x07, 0x0D on lanes 0–3 at cycles 6/12/18/24;
  - `done_o` at 24;
  - downstream packer holds 0x0205070D.
- Identity S-box, cipher 0xFFFFFFFF: data 0xFD, 0xFA, 0xF8, 0xF2.
- Pulse `start_i` at cycles 5 and 20 during a word: both ignored; exactly 4 strobes, one `done_o`.
- Assert `rst` in cycle 14: all outputs 0 in that cycle, busy low. Reload identity S-box, start: first byte is 0x02 again.
- After one word, pulse `init_i` together with `start_i` and reload identity S-box: output repeats 0x02, 0x05, 0x07, 0x0D.
- 64 back-to-back words from a random KSA'd S-box: all 256 bytes, including the i wrap 255→0, match the golden RC4 model.
